// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MEM    = 4'd4,
    S_WB     = 4'd5,
    S_TRAP   = 4'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    CL_R, CL_IALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_JALR, CL_JAL, CL_LUI
  } instr_class_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0, IMM_I_SHAMT = 3'd1, IMM_S = 3'd2, IMM_B = 3'd3,
    IMM_J = 3'd4, IMM_U = 3'd5, IMM_NONE = 3'd7
  } imm_sel_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3, ALU_SLTU = 4'd4,
    ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8, ALU_AND = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_ALU = 2'd1, PC_ALU_ALIGN = 2'd2} pc_src_t;
  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2} wb_sel_t;
  typedef enum logic [1:0] {SRC_A_RS1 = 2'd0, SRC_A_PC = 2'd1, SRC_A_ZERO = 2'd2} src_a_t;

  localparam logic [1:0] SRC_B_RS2 = 2'd0;
  localparam logic [1:0] SRC_B_IMM = 2'd1;

  // alt picks SUB/SRA; callers only raise it where that alternate is legal
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/riscv_ctrl_decode.sv
// Combinational instruction classifier: class, ALU op, immediate format, illegal flag.
module riscv_ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [2:0]  cls,
  output logic [3:0]  alu_op,
  output logic [2:0]  imm_sel,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_shift;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign is_shift      = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    cls     = CL_R;
    alu_op  = ALU_ADD;
    imm_sel = IMM_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        cls     = CL_R;
        alu_op  = alu_from_f3(funct3, funct7[5]);
        imm_sel = is_shift ? IMM_I_SHAMT : IMM_I;
        if (funct7 == 7'h20) illegal = !((funct3 == 3'b000) || (funct3 == 3'b101));
        else                 illegal = (funct7 != 7'h00);
      end
      OP_IALU: begin
        cls     = CL_IALU;
        alu_op  = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
        imm_sel = is_shift ? IMM_I_SHAMT : IMM_I;
        if (funct3 == 3'b001)      illegal = (funct7 != 7'h00);
        else if (funct3 == 3'b101) illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
      end
      OP_LOAD: begin
        cls     = CL_LOAD;
        imm_sel = IMM_I;
        illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        cls     = CL_STORE;
        imm_sel = IMM_S;
        illegal = (funct3 > 3'd2);
      end
      OP_BRANCH: begin
        cls     = CL_BRANCH;
        imm_sel = IMM_B;
        illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_JALR: begin
        cls     = CL_JALR;
        imm_sel = IMM_I;
        illegal = (funct3 != 3'b000);
      end
      OP_JAL: begin
        cls     = CL_JAL;
        imm_sel = IMM_J;
      end
      OP_LUI: begin
        cls     = CL_LUI;
        imm_sel = IMM_U;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_mc_control.sv
// Multi-cycle RV32I control FSM sharing one memory port between fetch and data access.
//   state  | meaning
//   IDLE   | one cycle after reset before the first fetch
//   FETCH  | instruction read on the shared port, IR loads on mem_ready
//   DECODE | classify IR, illegal encodings park in TRAP
//   EXEC   | ALU step; ALU/jump/branch retire here, load/store go to MEM
//   MEM    | data access using the ALU address
//   WB     | load data written to the register file
//   TRAP   | illegal instruction or bus timeout, held until reset
module riscv_mc_control
  import riscv_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [2:0]  imm_sel,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic        bus_err,
  output logic [3:0]  state_o
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [15:0] to_cnt, to_cnt_next;
  logic [2:0]  dec_cls;
  logic [3:0]  dec_alu_op;
  logic [2:0]  dec_imm_sel;
  logic        dec_illegal;
  logic        waiting;
  logic        timed_out;

  riscv_ctrl_decode u_decode (
    .instr   (instr),
    .cls     (dec_cls),
    .alu_op  (dec_alu_op),
    .imm_sel (dec_imm_sel),
    .illegal (dec_illegal)
  );

  assign state_o   = state;
  assign waiting   = (state == S_FETCH) || (state == S_MEM);
  // a ready in the final allowed cycle still completes, so the trap needs ready low
  assign timed_out = (TIMEOUT != 0) && waiting && !mem_ready && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      to_cnt  <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state  <= state_next;
      to_cnt <= to_cnt_next;
      if ((state == S_DECODE) && dec_illegal) illegal <= 1'b1;
      if (timed_out) bus_err <= 1'b1;
    end
  end

  always_comb begin
    to_cnt_next = '0;
    if (waiting && !mem_ready && (state_next == state)) to_cnt_next = to_cnt + 16'd1;
  end

  always_comb begin
    state_next   = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_PLUS4;
    imm_sel      = IMM_NONE;
    alu_src_a    = SRC_A_RS1;
    alu_src_b    = SRC_B_RS2;
    alu_op       = ALU_ADD;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;

    // MEM keeps the EXEC operand selects so the data address stays put
    if ((state == S_EXEC) || (state == S_MEM)) begin
      imm_sel   = dec_imm_sel;
      alu_op    = dec_alu_op;
      alu_src_b = (dec_cls == CL_R) ? SRC_B_RS2 : SRC_B_IMM;
      if ((dec_cls == CL_BRANCH) || (dec_cls == CL_JAL)) alu_src_a = SRC_A_PC;
      else if (dec_cls == CL_LUI)                         alu_src_a = SRC_A_ZERO;
    end

    case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (timed_out) state_next = S_TRAP;
        else if (mem_ready) begin
          ir_we      = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: state_next = dec_illegal ? S_TRAP : S_EXEC;
      S_EXEC: begin
        state_next = S_FETCH;
        case (dec_cls)
          CL_R, CL_IALU, CL_LUI: begin
            reg_we = 1'b1;
            pc_we  = 1'b1;
          end
          CL_BRANCH: begin
            pc_we  = 1'b1;
            pc_src = branch_taken ? PC_ALU : PC_PLUS4;
          end
          CL_JAL: begin
            reg_we = 1'b1;
            wb_sel = WB_PC4;
            pc_we  = 1'b1;
            pc_src = PC_ALU;
          end
          CL_JALR: begin
            reg_we = 1'b1;
            wb_sel = WB_PC4;
            pc_we  = 1'b1;
            pc_src = PC_ALU_ALIGN;
          end
          default: state_next = S_MEM;
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (dec_cls == CL_STORE);
        if (timed_out) state_next = S_TRAP;
        else if (mem_ready) begin
          if (dec_cls == CL_STORE) begin
            pc_we      = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        wb_sel     = WB_MEM;
        pc_we      = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_riscv_mc_control.sv
// Self-checking bench for riscv_mc_control: per-cycle expectations queued and drained at negedge.
module tb_riscv_mc_control;

  localparam int F_STATE = 0, F_REQ = 1, F_WE = 2, F_ASEL = 3, F_IRWE = 4, F_PCWE = 5,
                 F_PCSRC = 6, F_IMM = 7, F_SRCA = 8, F_SRCB = 9, F_OP = 10, F_RWE = 11,
                 F_WB = 12, F_ILL = 13, F_BERR = 14;

  typedef struct {
    string name;
    int    sel;
    int    val;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic        bt;
    int imm; int a; int b; int op; int rwe; int wb; int ps;
    bit chk_b; bit chk_op;
  } ex_t;

  logic        clk = 1'b0;
  logic        rst_n, branch_taken, mem_ready;
  logic [31:0] instr;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we, illegal, bus_err;
  logic [1:0]  pc_src, alu_src_a, alu_src_b, wb_sel;
  logic [2:0]  imm_sel;
  logic [3:0]  alu_op, state_o;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  riscv_mc_control #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .imm_sel(imm_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we),
    .wb_sel(wb_sel), .illegal(illegal), .bus_err(bus_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] field(int s);
    case (s)
      F_STATE: return 32'(state_o);
      F_REQ:   return 32'(mem_req);
      F_WE:    return 32'(mem_we);
      F_ASEL:  return 32'(mem_addr_sel);
      F_IRWE:  return 32'(ir_we);
      F_PCWE:  return 32'(pc_we);
      F_PCSRC: return 32'(pc_src);
      F_IMM:   return 32'(imm_sel);
      F_SRCA:  return 32'(alu_src_a);
      F_SRCB:  return 32'(alu_src_b);
      F_OP:    return 32'(alu_op);
      F_RWE:   return 32'(reg_we);
      F_WB:    return 32'(wb_sel);
      F_ILL:   return 32'(illegal);
      default: return 32'(bus_err);
    endcase
  endfunction

  task automatic push_exp(string n, int s, int v);
    sb.push_back('{n, s, v});
  endtask

  // leaves the DUT in its first FETCH cycle, one time unit after the edge
  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_t e; logic [31:0] got;
    rst_n = 1'b0; mem_ready = 1'b1; branch_taken = 1'b0; instr = 32'h00500093;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) begin
        repeat (2) @(posedge clk);
        push_exp("rst_state", F_STATE, 0); push_exp("rst_req", F_REQ, 0);
        push_exp("rst_irwe", F_IRWE, 0);   push_exp("rst_pcwe", F_PCWE, 0);
        push_exp("rst_rwe", F_RWE, 0);     push_exp("rst_imm", F_IMM, 7);
        push_exp("rst_ill", F_ILL, 0);     push_exp("rst_berr", F_BERR, 0);
        push_exp("rst_we", F_WE, 0);       push_exp("rst_op", F_OP, 0);
      end else begin
        push_exp("rel_state", F_STATE, 1); push_exp("rel_req", F_REQ, 1);
        push_exp("rel_asel", F_ASEL, 0);
      end
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = field(e.sel); checks++;
        if (got !== 32'(e.val)) begin
          errors++; $display("FAIL %s: got %0d want %0d", e.name, got, e.val);
        end
      end
      rst_n = 1'b1; mem_ready = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_exec_table();
    exp_t e; logic [31:0] got; ex_t tbl[10];
    tbl[0] = '{32'h00500093, 1'b0, 0, 0, 1, 0, 1, 0, 0, 1'b1, 1'b1}; // addi
    tbl[1] = '{32'h40208033, 1'b0, 0, 0, 0, 1, 1, 0, 0, 1'b1, 1'b1}; // sub
    tbl[2] = '{32'h4021D193, 1'b0, 1, 0, 1, 7, 1, 0, 0, 1'b1, 1'b1}; // srai
    tbl[3] = '{32'h0020B1B3, 1'b0, 0, 0, 0, 4, 1, 0, 0, 1'b1, 1'b1}; // sltu
    tbl[4] = '{32'h0FF0F093, 1'b0, 0, 0, 1, 9, 1, 0, 0, 1'b1, 1'b1}; // andi
    tbl[5] = '{32'h123450B7, 1'b0, 5, 2, 1, 0, 1, 0, 0, 1'b0, 1'b1}; // lui
    tbl[6] = '{32'hFE000EE3, 1'b1, 3, 1, 1, 0, 0, 0, 1, 1'b0, 1'b1}; // beq taken
    tbl[7] = '{32'hFE000EE3, 1'b0, 3, 1, 1, 0, 0, 0, 0, 1'b0, 1'b1}; // beq not taken
    tbl[8] = '{32'h0000006F, 1'b0, 4, 1, 1, 0, 1, 2, 1, 1'b0, 1'b0}; // jal
    tbl[9] = '{32'h00008067, 1'b0, 0, 0, 1, 0, 1, 2, 2, 1'b0, 1'b0}; // jalr
    foreach (tbl[i]) begin
      do_reset();
      instr = tbl[i].ins; branch_taken = tbl[i].bt;
      for (int c = 0; c < 4; c++) begin
        mem_ready = (c == 0);
        case (c)
          0: begin push_exp($sformatf("t%0d_f_state", i), F_STATE, 1);
                   push_exp($sformatf("t%0d_f_irwe", i), F_IRWE, 1); end
          1: begin push_exp($sformatf("t%0d_d_state", i), F_STATE, 2);
                   push_exp($sformatf("t%0d_d_rwe", i), F_RWE, 0); end
          2: begin
            push_exp($sformatf("t%0d_e_state", i), F_STATE, 3);
            push_exp($sformatf("t%0d_e_imm", i), F_IMM, tbl[i].imm);
            push_exp($sformatf("t%0d_e_srca", i), F_SRCA, tbl[i].a);
            push_exp($sformatf("t%0d_e_rwe", i), F_RWE, tbl[i].rwe);
            push_exp($sformatf("t%0d_e_pcwe", i), F_PCWE, 1);
            push_exp($sformatf("t%0d_e_pcsrc", i), F_PCSRC, tbl[i].ps);
            push_exp($sformatf("t%0d_e_req", i), F_REQ, 0);
            if (tbl[i].chk_b)  push_exp($sformatf("t%0d_e_srcb", i), F_SRCB, tbl[i].b);
            if (tbl[i].chk_op) push_exp($sformatf("t%0d_e_op", i), F_OP, tbl[i].op);
            if (tbl[i].rwe != 0) push_exp($sformatf("t%0d_e_wb", i), F_WB, tbl[i].wb);
          end
          default: begin push_exp($sformatf("t%0d_n_state", i), F_STATE, 1);
                         push_exp($sformatf("t%0d_n_req", i), F_REQ, 1); end
        endcase
        @(negedge clk);
        while (sb.size() > 0) begin
          e = sb.pop_front(); got = field(e.sel); checks++;
          if (got !== 32'(e.val)) begin
            errors++; $display("FAIL %s: got %0d want %0d", e.name, got, e.val);
          end
        end
        @(posedge clk); #1;
      end
    end
  endtask

  // lw with two wait states: FETCH DECODE EXEC MEM MEM MEM WB FETCH
  task automatic test_load_wait();
    exp_t e; logic [31:0] got;
    int st[8] = '{1, 2, 3, 4, 4, 4, 5, 1};
    do_reset();
    instr = 32'h0080A103;
    for (int c = 0; c < 8; c++) begin
      mem_ready = (c == 0) || (c == 5);
      push_exp($sformatf("ld_c%0d_state", c), F_STATE, st[c]);
      if (st[c] == 4) begin
        push_exp($sformatf("ld_c%0d_req", c), F_REQ, 1);
        push_exp($sformatf("ld_c%0d_asel", c), F_ASEL, 1);
        push_exp($sformatf("ld_c%0d_we", c), F_WE, 0);
        push_exp($sformatf("ld_c%0d_rwe", c), F_RWE, 0);
        push_exp($sformatf("ld_c%0d_imm", c), F_IMM, 0);
      end
      if (st[c] == 5) begin
        push_exp("ld_wb_rwe", F_RWE, 1); push_exp("ld_wb_sel", F_WB, 1);
        push_exp("ld_wb_pcwe", F_PCWE, 1); push_exp("ld_wb_pcsrc", F_PCSRC, 0);
        push_exp("ld_wb_req", F_REQ, 0);
      end
      if (c == 2) begin push_exp("ld_e_pcwe", F_PCWE, 0); push_exp("ld_e_srcb", F_SRCB, 1); end
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = field(e.sel); checks++;
        if (got !== 32'(e.val)) begin
          errors++; $display("FAIL %s: got %0d want %0d", e.name, got, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // sw x2,4(x1) with zero-wait memory: 4 cycles then FETCH
  task automatic test_store();
    exp_t e; logic [31:0] got;
    int st[5] = '{1, 2, 3, 4, 1};
    do_reset();
    instr = 32'h0020A223;
    for (int c = 0; c < 5; c++) begin
      mem_ready = (c == 0) || (c == 3);
      push_exp($sformatf("st_c%0d_state", c), F_STATE, st[c]);
      if (c == 2) push_exp("st_e_imm", F_IMM, 2);
      if (c == 3) begin
        push_exp("st_m_we", F_WE, 1);     push_exp("st_m_req", F_REQ, 1);
        push_exp("st_m_asel", F_ASEL, 1); push_exp("st_m_pcwe", F_PCWE, 1);
        push_exp("st_m_pcsrc", F_PCSRC, 0); push_exp("st_m_rwe", F_RWE, 0);
        push_exp("st_m_imm", F_IMM, 2);
      end
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = field(e.sel); checks++;
        if (got !== 32'(e.val)) begin
          errors++; $display("FAIL %s: got %0d want %0d", e.name, got, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    exp_t e; logic [31:0] got;
    logic [31:0] bad[4] = '{32'h40219193, 32'h0000007F, 32'h00002063, 32'h0000B003};
    foreach (bad[i]) begin
      do_reset();
      instr = bad[i];
      for (int c = 0; c < 4; c++) begin
        mem_ready = (c == 0) || (c == 3);
        case (c)
          0: push_exp($sformatf("il%0d_f_ill", i), F_ILL, 0);
          1: begin push_exp($sformatf("il%0d_d_state", i), F_STATE, 2);
                   push_exp($sformatf("il%0d_d_ill", i), F_ILL, 0); end
          default: begin
            push_exp($sformatf("il%0d_c%0d_state", i, c), F_STATE, 6);
            push_exp($sformatf("il%0d_c%0d_ill", i, c), F_ILL, 1);
            push_exp($sformatf("il%0d_c%0d_rwe", i, c), F_RWE, 0);
            push_exp($sformatf("il%0d_c%0d_pcwe", i, c), F_PCWE, 0);
            push_exp($sformatf("il%0d_c%0d_req", i, c), F_REQ, 0);
            push_exp($sformatf("il%0d_c%0d_berr", i, c), F_BERR, 0);
          end
        endcase
        @(negedge clk);
        while (sb.size() > 0) begin
          e = sb.pop_front(); got = field(e.sel); checks++;
          if (got !== 32'(e.val)) begin
            errors++; $display("FAIL %s: got %0d want %0d", e.name, got, e.val);
          end
        end
        @(posedge clk); #1;
      end
    end
  endtask

  // ready_at < 0: memory never answers; otherwise ready in that FETCH cycle
  task automatic test_fetch_timeout(int ready_at);
    exp_t e; logic [31:0] got;
    do_reset();
    instr = 32'h00500093;
    for (int c = 0; c < 6; c++) begin
      mem_ready = (c == ready_at);
      if (ready_at < 0) begin
        if (c < 4) begin
          push_exp($sformatf("to_c%0d_state", c), F_STATE, 1);
          push_exp($sformatf("to_c%0d_irwe", c), F_IRWE, 0);
          push_exp($sformatf("to_c%0d_berr", c), F_BERR, 0);
        end else begin
          push_exp($sformatf("to_c%0d_state", c), F_STATE, 6);
          push_exp($sformatf("to_c%0d_berr", c), F_BERR, 1);
          push_exp($sformatf("to_c%0d_irwe", c), F_IRWE, 0);
          push_exp($sformatf("to_c%0d_req", c), F_REQ, 0);
          push_exp($sformatf("to_c%0d_ill", c), F_ILL, 0);
        end
      end else begin
        push_exp($sformatf("tb_c%0d_state", c), F_STATE, (c <= ready_at) ? 1 : (c == ready_at + 1) ? 2 : 3);
        push_exp($sformatf("tb_c%0d_irwe", c), F_IRWE, (c == ready_at) ? 1 : 0);
        push_exp($sformatf("tb_c%0d_berr", c), F_BERR, 0);
      end
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = field(e.sel); checks++;
        if (got !== 32'(e.val)) begin
          errors++; $display("FAIL %s: got %0d want %0d", e.name, got, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_timeout();
    exp_t e; logic [31:0] got;
    int st[9] = '{1, 2, 3, 4, 4, 4, 4, 6, 6};
    do_reset();
    instr = 32'h0080A103;
    for (int c = 0; c < 9; c++) begin
      mem_ready = (c == 0);
      push_exp($sformatf("mt_c%0d_state", c), F_STATE, st[c]);
      push_exp($sformatf("mt_c%0d_rwe", c), F_RWE, 0);
      push_exp($sformatf("mt_c%0d_berr", c), F_BERR, (st[c] == 6) ? 1 : 0);
      if (st[c] == 4) push_exp($sformatf("mt_c%0d_req", c), F_REQ, 1);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = field(e.sel); checks++;
        if (got !== 32'(e.val)) begin
          errors++; $display("FAIL %s: got %0d want %0d", e.name, got, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; logic [31:0] got;
    int st[4] = '{1, 1, 0, 1};
    int rq[4] = '{1, 1, 0, 1};
    do_reset();
    instr = 32'h00500093;
    for (int c = 0; c < 4; c++) begin
      mem_ready = 1'b0;
      rst_n = (c != 1);
      push_exp($sformatf("rm_c%0d_state", c), F_STATE, st[c]);
      push_exp($sformatf("rm_c%0d_req", c), F_REQ, rq[c]);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = field(e.sel); checks++;
        if (got !== 32'(e.val)) begin
          errors++; $display("FAIL %s: got %0d want %0d", e.name, got, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; branch_taken = 1'b0; mem_ready = 1'b0; instr = '0;
    test_reset();
    test_exec_table();
    test_load_wait();
    test_store();
    test_illegal();
    test_fetch_timeout(-1);
    test_fetch_timeout(3);
    test_mem_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_mc_control.md
# riscv_mc_control

Multi-cycle control FSM for the RV32I core. Sequences fetch, decode, execute, memory and write-back over a single shared memory port. Drives the immediate-generator select, ALU operand/op selects, register-file write enable and PC update. Flags illegal instructions and memory timeouts by parking in a trap state.

## Interface
- TIMEOUT, default 255: maximum `mem_ready`-low cycles per request; 0 disables the timeout.
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- instr  in  32  current instruction-register contents
- branch_taken  in  1  external comparator result for the current branch
- mem_ready  in  1  memory completes the request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  store request
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_we  out  1  load the instruction register
- pc_we  out  1  update the PC
- pc_src  out  2  0 = PC+4, 1 = ALU result, 2 = ALU result & ~1
- imm_sel  out  3  0 I, 1 I_SHAMT, 2 S, 3 B, 4 J, 5 U, 7 none
- alu_src_a  out  2  0 rs1, 1 PC, 2 zero
- alu_src_b  out  2  0 rs2, 1 imm
- alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
- reg_we  out  1  register-file write
- wb_sel  out  2  0 ALU, 1 memory data, 2 PC+4
- illegal  out  1  sticky; set on an illegal instruction
- bus_err  out  1  sticky; set on a memory timeout
- state_o  out  4  current state, for debug

## Operation
- **States:** IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- **Reset:** state = IDLE. All outputs are 0 except `imm_sel` = 7. Timeout counter = 0.
- **IDLE → FETCH:** unconditional, one cycle.
- **FETCH:**
  - Asserts `mem_req` with `mem_addr_sel` = 0.
  - On `mem_ready`, asserts `ir_we` and goes to DECODE.
- **DECODE:**
  - Classifies `instr[6:0]`: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JALR 1100111, JAL 1101111, LUI 0110111.
  - Any other opcode, or a bad funct field, goes to TRAP with `illegal` = 1. Otherwise goes to EXEC.
- **Illegal encodings:**
  - Shift funct7 other than 0 (or 0x20 for SRL/SRA).
  - R-type funct7 0x20 with funct3 not 000/101, or any other nonzero R-type funct7.
  - Branch funct3 010/011.
  - Load funct3 011/110/111.
  - Store funct3 above 2.
  - JALR funct3 not 0.
- **EXEC, per instruction class:**
  - R / I-ALU:
    - `alu_op` from funct3, with funct7[5] selecting SUB/SRA.
    - `imm_sel` = I_SHAMT for funct3 001/101, else I.
    - `reg_we` = 1, `wb_sel` = 0, `pc_we` = 1, `pc_src` = 0; next state FETCH.
  - LUI: `alu_src_a` = zero, `imm_sel` = U, ADD, `reg_we`, `pc_we` with `pc_src` = 0; next state FETCH.
  - BRANCH: `alu_src_a` = PC, `imm_sel` = B, ADD, `pc_we`; `pc_src` = `branch_taken` ? 1 : 0; next state FETCH.
  - JAL: `alu_src_a` = PC, `imm_sel` = J; `reg_we` with `wb_sel` = 2; `pc_we` with `pc_src` = 1; next state FETCH.
  - JALR: `alu_src_a` = rs1, `imm_sel` = I; `reg_we` with `wb_sel` = 2; `pc_we` with `pc_src` = 2; next state FETCH.
  - LOAD / STORE: `alu_src_a` = rs1, `imm_sel` = I / S, ADD; next state MEM.
- **MEM:**
  - Holds the address selects, `mem_addr_sel` = 1, `mem_req`, and `mem_we` (= store).
  - On `mem_ready`: a store asserts `pc_we` with `pc_src` = 0 and goes to FETCH; a load goes to WB.
- **WB:** `reg_we`, `wb_sel` = 1, `pc_we` with `pc_src` = 0; next state FETCH.
- **TRAP:** all strobes 0; held until reset.

## Timing
- Outputs are decoded from the registered state plus `instr` (Moore per state; EXEC is combinational on `instr` and `branch_taken`).
- **Latency with zero-wait memory:**
  - ALU / LUI / branch / jump: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each `mem_ready`-low cycle in FETCH or MEM adds one cycle.
- **Request hold:** `mem_req`, `mem_we` and `mem_addr_sel` stay stable until `mem_ready` is sampled high. `mem_ready` is ignored while `mem_req` = 0.
- **Timeout:**
  - The counter increments each FETCH/MEM cycle with `mem_ready` low, and clears on `mem_ready` or on a state change.
  - Reaching TIMEOUT goes to TRAP with `bus_err` = 1, no `ir_we`, `pc_we` or `reg_we`.
  - `mem_ready` in the same cycle as reaching TIMEOUT counts as completion.
- **Reset mid-request:** the in-flight request is abandoned. `mem_req` drops the cycle after the `rst_n`-low edge; state goes to IDLE.
- **`reg_we` to x0:** the register file handles rd = 0; the controller does not gate it.

## Structure
- **Package `riscv_ctrl_pkg`:** `state_t` enum, opcode localparams, `imm_sel_t`, `alu_op_t`, `pc_src_t`, `wb_sel_t`.
- **Sub-module `riscv_ctrl_decode`:** combinational. Maps `instr` to class, `alu_op`, `imm_sel` and illegal. The FSM lives in `riscv_mc_control`.

## Test plan
- **Reset:** hold `rst_n` = 0 for 2 cycles → all strobes 0, `state_o` = IDLE. Release → FETCH next cycle with `mem_req` = 1.
- **ADDI:** 0x00500093 (addi x1,x0,5), `mem_ready` = 1 → EXEC shows `imm_sel` = 0, `alu_op` = 0, `alu_src_b` = 1, `reg_we` = 1, `pc_we` = 1, `pc_src` = 0. FETCH again after 3 cycles.
- **Load with wait states:** 0x0080A103 (lw x2,8(x1)), `mem_ready` low 2 cycles in MEM → `mem_req` held 3 cycles with `mem_addr_sel` = 1, `mem_we` = 0. Then WB with `reg_we` = 1, `wb_sel` = 1.
- **Branch:** 0xFE000EE3 (beq x0,x0,-4) → `imm_sel` = 3. `branch_taken` = 1 gives `pc_src` = 1; `branch_taken` = 0 gives `pc_src` = 0.
- **Shifts:** 0x4021D193 (srai) → `alu_op` = 7, `imm_sel` = 1. 0x40219193 (slli with funct7 0x20) → TRAP, `illegal` = 1, no `reg_we`.
- **Timeout:** TIMEOUT = 4, `mem_ready` stuck 0 in FETCH → TRAP after 4 cycles, `bus_err` = 1, `ir_we` never asserted.
